// File: rtl/zeptron_pkg.sv
// Shared Zeptron RV32 core constants and types.
// Holds the datapath width and the reset bubble used by the pipeline boundary registers.
package zeptron_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] word_t;

  // addi x0,x0,0: decode treats it as a no-op bubble.
  localparam word_t NOP_INSTR = 32'h0000_0013;
  localparam word_t RESET_PC  = 32'h0000_0000;

endpackage

// File: rtl/if_id_reg_if.sv
// Fetch-to-decode boundary bundle.
// The fetch side drives the f_* fields and the stall control; decode consumes the d_* fields.
interface if_id_reg_if
  import zeptron_pkg::*;
;

  logic  enable;
  word_t f_instr;
  word_t f_pc;
  word_t d_instr;
  word_t d_pc;
  word_t d_pc4;
  logic  d_valid;

  modport master (
    output enable, f_instr, f_pc,
    input  d_instr, d_pc, d_pc4, d_valid
  );

  modport slave (
    input  enable, f_instr, f_pc,
    output d_instr, d_pc, d_pc4, d_valid
  );

endinterface

// File: rtl/pipe_reg_en.sv
// Generic W-bit pipeline register with synchronous active-high reset and load enable.
// Reset has priority over the enable; with the enable low the register holds its contents.
module pipe_reg_en #(
  parameter int           W       = 32,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  // NOTE: non-blocking assignment so every register samples pre-edge values, whatever the block order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= RST_VAL;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/if_id_reg.sv
// IF/ID pipeline boundary register of the Zeptron RV32 core.
// Captures instruction and pc on enabled edges, holds on stall, and loads a NOP bubble on reset.
module if_id_reg
  import zeptron_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  if_id_reg_if.slave  bus
);

  word_t w_instr;
  word_t w_pc;
  logic  w_valid;

  pipe_reg_en #(.W(XLEN), .RST_VAL(NOP_INSTR)) u_instr_reg (
    .clk   (clk),
    .reset (reset),
    .i_en  (bus.enable),
    .i_d   (bus.f_instr),
    .o_q   (w_instr)
  );

  pipe_reg_en #(.W(XLEN), .RST_VAL(RESET_PC)) u_pc_reg (
    .clk   (clk),
    .reset (reset),
    .i_en  (bus.enable),
    .i_d   (bus.f_pc),
    .o_q   (w_pc)
  );

  // Any enabled capture marks the stage as holding a real instruction.
  pipe_reg_en #(.W(1), .RST_VAL(1'b0)) u_valid_reg (
    .clk   (clk),
    .reset (reset),
    .i_en  (bus.enable),
    .i_d   (1'b1),
    .o_q   (w_valid)
  );

  assign bus.d_instr = w_instr;
  assign bus.d_pc    = w_pc;
  assign bus.d_pc4   = w_pc + word_t'(4);
  assign bus.d_valid = w_valid;

endmodule

// File: tb/tb_if_id_reg.sv
// Self-checking bench for if_id_reg: reset phase, a table of directed vectors, and a stall sequence.
// Inputs change on the falling edge; outputs are sampled on the falling edge after each rising edge.
module tb_if_id_reg;
  import zeptron_pkg::*;

  typedef struct {
    string name;
    logic  reset;
    logic  enable;
    word_t f_instr;
    word_t f_pc;
    word_t exp_instr;
    word_t exp_pc;
    word_t exp_pc4;
    logic  exp_valid;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  vec_t vecs[10];

  if_id_reg_if bus ();

  if_id_reg dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #1 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input word_t e_instr, input word_t e_pc,
                               input word_t e_pc4, input logic e_valid);
    check({tag, ".d_instr"}, bus.d_instr, e_instr);
    check({tag, ".d_pc"},    bus.d_pc,    e_pc);
    check({tag, ".d_pc4"},   bus.d_pc4,   e_pc4);
    check({tag, ".d_valid"}, {31'd0, bus.d_valid}, {31'd0, e_valid});
  endtask

  initial begin
    #10000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks   = 0;
    failures = 0;

    // name, reset, enable, f_instr, f_pc, exp_instr, exp_pc, exp_pc4, exp_valid
    vecs[0] = '{"first_capture", 1'b0, 1'b1, 32'h0000_00A1, 32'h0000_0049,
                32'h0000_00A1, 32'h0000_0049, 32'h0000_004D, 1'b1};
    vecs[1] = '{"stall_0",       1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0000_0100,
                32'h0000_00A1, 32'h0000_0049, 32'h0000_004D, 1'b1};
    vecs[2] = '{"stall_1",       1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0000_0100,
                32'h0000_00A1, 32'h0000_0049, 32'h0000_004D, 1'b1};
    vecs[3] = '{"stall_2",       1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0000_0100,
                32'h0000_00A1, 32'h0000_0049, 32'h0000_004D, 1'b1};
    vecs[4] = '{"resume",        1'b0, 1'b1, 32'hDEAD_BEEF, 32'h0000_0100,
                32'hDEAD_BEEF, 32'h0000_0100, 32'h0000_0104, 1'b1};
    vecs[5] = '{"reset_in_stall",1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0000_0100,
                32'h0000_0013, 32'h0000_0000, 32'h0000_0004, 1'b0};
    vecs[6] = '{"idle_after_rst",1'b0, 1'b0, 32'h0000_0055, 32'h0000_0088,
                32'h0000_0013, 32'h0000_0000, 32'h0000_0004, 1'b0};
    vecs[7] = '{"pc4_wrap",      1'b0, 1'b1, 32'h1234_5678, 32'hFFFF_FFFC,
                32'h1234_5678, 32'hFFFF_FFFC, 32'h0000_0000, 1'b1};
    vecs[8] = '{"reset_over_en", 1'b1, 1'b1, 32'hCAFE_F00D, 32'h0000_0200,
                32'h0000_0013, 32'h0000_0000, 32'h0000_0004, 1'b0};
    vecs[9] = '{"capture_again", 1'b0, 1'b1, 32'h0040_0093, 32'h0000_0010,
                32'h0040_0093, 32'h0000_0010, 32'h0000_0014, 1'b1};

    // Reset held for 0..20 with enable high: every edge must show the bubble.
    reset       = 1'b1;
    bus.enable  = 1'b1;
    bus.f_instr = 32'h0000_00A1;
    bus.f_pc    = 32'h0000_0049;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_outputs($sformatf("reset_edge%0d", i), 32'h0000_0013, 32'h0000_0000,
                    32'h0000_0004, 1'b0);
    end

    for (int i = 0; i < 10; i++) begin
      reset       = vecs[i].reset;
      bus.enable  = vecs[i].enable;
      bus.f_instr = vecs[i].f_instr;
      bus.f_pc    = vecs[i].f_pc;
      @(negedge clk);
      check_outputs(vecs[i].name, vecs[i].exp_instr, vecs[i].exp_pc,
                    vecs[i].exp_pc4, vecs[i].exp_valid);
    end

    // Long stall with changing inputs: contents must not move.
    bus.enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.f_instr = 32'h1111_0000 + 32'(i);
      bus.f_pc    = 32'h0000_4000 + 32'(i * 4);
      @(negedge clk);
      check_outputs($sformatf("hold_seq%0d", i), 32'h0040_0093, 32'h0000_0010,
                    32'h0000_0014, 1'b1);
    end

    // Back-to-back enabled captures: each edge presents the previous edge's inputs.
    bus.enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.f_instr = 32'hA000_0000 | 32'(i);
      bus.f_pc    = 32'h0000_8000 + 32'(i * 4);
      @(negedge clk);
      check_outputs($sformatf("stream%0d", i), 32'hA000_0000 | 32'(i),
                    32'h0000_8000 + 32'(i * 4), 32'h0000_8004 + 32'(i * 4), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
